// File: rtl/frame_stream_reader.sv
// frame_stream_reader: replays a stored raster frame from a BRAM frame buffer as a
// valid/ready pixel stream tagged with hcount/vcount. Reads are issued against a
// credit (FIFO occupancy + reads still in flight) so the skid FIFO can always absorb
// every word that returns, no matter how long the consumer stalls.
module frame_stream_reader #(
  parameter int WIDTH      = 240,
  parameter int HEIGHT     = 320,
  parameter int PIX_W      = 7,
  parameter int ADDR_W     = 17,
  parameter int READ_LAT   = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              start_in,
  output logic [ADDR_W-1:0] addr_out,
  input  logic [PIX_W-1:0]  bram_data_in,
  output logic [PIX_W-1:0]  pixel_out,
  output logic [10:0]       hcount_out,
  output logic [9:0]        vcount_out,
  output logic              valid_out,
  input  logic              ready_in,
  output logic              busy_out,
  output logic              frame_done_out
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(WIDTH * HEIGHT - 1);
  localparam logic [10:0]       H_LAST    = 11'(WIDTH - 1);
  localparam logic [9:0]        V_LAST    = 10'(HEIGHT - 1);
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W:0]    CREDITS   = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t state, state_next;

  logic [ADDR_W-1:0] next_addr;
  logic [ADDR_W-1:0] last_addr;
  logic [READ_LAT-1:0] pipe;
  logic [CNT_W-1:0] inflight;
  logic [PIX_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] fifo_count;
  logic [10:0] hcount;
  logic [9:0]  vcount;

  logic start_ok, credit_ok, issue, last_issue, busy;
  logic push, pop, fifo_valid, last_xfer;

  assign start_ok   = start_in && (state == IDLE);
  assign push       = pipe[READ_LAT-1];
  assign fifo_valid = (fifo_count != '0);
  assign pop        = fifo_valid && ready_in;
  assign last_xfer  = pop && (hcount == H_LAST) && (vcount == V_LAST);
  assign last_issue = issue && (next_addr == ADDR_LAST);

  // Count reads that have been issued but whose data has not yet landed
  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LAT; i++) begin
      inflight = inflight + CNT_W'(pipe[i]);
    end
  end

  // A read may only go out if its returning word is guaranteed a FIFO slot
  assign credit_ok = ({1'b0, fifo_count} + {1'b0, inflight}) < CREDITS;

  // State register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic: issue all addresses, then wait for the final transfer
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_in)   state_next = ISSUE;
      ISSUE:   if (last_issue) state_next = DRAIN;
      DRAIN:   if (last_xfer)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State-decoded outputs: read strobe and busy flag
  always_comb begin
    issue = 1'b0;
    busy  = 1'b0;
    case (state)
      ISSUE:   begin issue = credit_ok; busy = 1'b1; end
      DRAIN:   busy = 1'b1;
      default: ;
    endcase
  end

  // Address generator: addr_out shows the address being issued, else the last one issued
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      next_addr <= '0;
      last_addr <= '0;
    end else if (start_ok) begin
      next_addr <= '0;
    end else if (issue) begin
      last_addr <= next_addr;
      if (next_addr != ADDR_LAST) next_addr <= next_addr + ADDR_W'(1);
    end
  end

  assign addr_out = issue ? next_addr : last_addr;

  // Read-latency tracker: a marker walks alongside each read until its data is valid
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pipe <= '0;
    end else begin
      pipe[0] <= issue;
      for (int i = 1; i < READ_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  // Skid FIFO storage: no reset needed, the head is masked whenever the FIFO is empty
  always_ff @(posedge clk_in) begin
    if (push) mem[wr_ptr] <= bram_data_in;
  end

  // Skid FIFO pointers and occupancy
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // The credit check makes a push into a full FIFO impossible
  assert property (@(posedge clk_in) disable iff (rst_in)
                   !(push && !pop && (fifo_count == FULL_CNT)));

  // Output raster position: advances on every transfer, wraps at line and frame end
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      hcount <= '0;
      vcount <= '0;
    end else if (start_ok) begin
      hcount <= '0;
      vcount <= '0;
    end else if (pop) begin
      if (hcount == H_LAST) begin
        hcount <= '0;
        vcount <= (vcount == V_LAST) ? '0 : vcount + 10'd1;
      end else begin
        hcount <= hcount + 11'd1;
      end
    end
  end

  assign valid_out      = fifo_valid;
  assign pixel_out      = fifo_valid ? mem[rd_ptr] : '0;
  assign hcount_out     = hcount;
  assign vcount_out     = vcount;
  assign busy_out       = busy;
  assign frame_done_out = last_xfer;

endmodule

// File: tb/tb_frame_stream_reader.sv
// tb_frame_stream_reader: scoreboard bench for frame_stream_reader. A small 4x3 instance
// is exercised with directed and random ready patterns; a default 240x320 instance runs
// one full frame alongside it.
module tb_frame_stream_reader;

  localparam int W = 4, H = 3, N = W * H;
  localparam int DEPTH = 4;
  localparam int BW = 240, BH = 320, BN = BW * BH;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Small instance signals
  logic        rst, start, ready, valid, busy, done;
  logic [16:0] addr;
  logic [6:0]  bram_data, pixel;
  logic [10:0] hcount;
  logic [9:0]  vcount;

  // Large instance signals
  logic        big_rst, big_start, big_valid, big_busy, big_done;
  logic [16:0] big_addr;
  logic [6:0]  big_bram_data, big_pixel;
  logic [10:0] big_hcount;
  logic [9:0]  big_vcount;

  frame_stream_reader #(
    .WIDTH(W), .HEIGHT(H), .PIX_W(7), .ADDR_W(17), .READ_LAT(2), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_in(clk), .rst_in(rst), .start_in(start), .addr_out(addr),
    .bram_data_in(bram_data), .pixel_out(pixel), .hcount_out(hcount),
    .vcount_out(vcount), .valid_out(valid), .ready_in(ready),
    .busy_out(busy), .frame_done_out(done)
  );

  frame_stream_reader dut_big (
    .clk_in(clk), .rst_in(big_rst), .start_in(big_start), .addr_out(big_addr),
    .bram_data_in(big_bram_data), .pixel_out(big_pixel), .hcount_out(big_hcount),
    .vcount_out(big_vcount), .valid_out(big_valid), .ready_in(1'b1),
    .busy_out(big_busy), .frame_done_out(big_done)
  );

  // BRAM models: two-cycle read latency, contents pixel[a] = a
  logic [16:0] b1, b2, bb1, bb2;
  always @(posedge clk) begin
    b1  <= addr;     b2  <= b1;
    bb1 <= big_addr; bb2 <= bb1;
  end
  assign bram_data     = b2[6:0];
  assign big_bram_data = bb2[6:0];

  typedef struct {
    int pix;
    int h;
    int v;
    int last;
  } beat_t;

  beat_t exp_q[$];
  int n_cmp = 0;
  int n_fail = 0;
  int done_cnt = 0;
  bit big_finished = 0;

  task automatic check_output(string name, int actual, int expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Reference model: one frame is the addresses 0..N-1 in raster order
  task automatic push_frame();
    for (int a = 0; a < N; a++) begin
      exp_q.push_back('{pix: a % 128, h: a % W, v: a / W, last: (a == N - 1) ? 1 : 0});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(string name, int budget);
    int k = 0;
    while ((exp_q.size() != 0 || busy) && k < budget) begin
      tick();
      k++;
    end
    check_output({name, "_drained_in_time"}, (k < budget) ? 1 : 0, 1);
    check_output({name, "_queue_left"}, exp_q.size(), 0);
    check_output({name, "_valid_after"}, valid, 0);
    check_output({name, "_h_wrapped"}, hcount, 0);
    check_output({name, "_v_wrapped"}, vcount, 0);
  endtask

  // Monitor: pops the scoreboard on every transfer, checks hold-under-stall and busy fall
  bit stalled = 0, prev_done = 0;
  int held_pix, held_h, held_v;
  always @(negedge clk) begin
    if (rst) begin
      stalled   = 0;
      prev_done = 0;
    end else begin
      if (prev_done) check_output("busy_after_done", busy, 0);
      if (stalled) begin
        check_output("stall_valid_held", valid, 1);
        check_output("stall_pix_held", pixel, held_pix);
        check_output("stall_h_held", hcount, held_h);
        check_output("stall_v_held", vcount, held_v);
      end
      if (valid && ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("[TB] FAIL unexpected_beat: got pix %0d h %0d v %0d, expected none",
                   pixel, hcount, vcount);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check_output("beat_pix", pixel, e.pix);
          check_output("beat_h", hcount, e.h);
          check_output("beat_v", vcount, e.v);
          check_output("beat_done", done, e.last);
        end
        if (done) done_cnt++;
      end else begin
        check_output("done_without_xfer", done, 0);
      end
      stalled   = valid && !ready;
      held_pix  = pixel;
      held_h    = hcount;
      held_v    = vcount;
      prev_done = valid && ready && done;
    end
  end

  // Full-size frame on the default-parameter instance
  initial begin
    int idx = 0, bad = 0, maxa = 0, dcnt = 0, last_h = -1, last_v = -1, last_cyc = -1;
    big_rst = 1'b1;
    big_start = 1'b0;
    repeat (3) @(posedge clk);
    #1 big_rst = 1'b0;
    tick();
    big_start = 1'b1;
    tick();
    big_start = 1'b0;
    for (int c = 1; c < BN + 200 && last_cyc < 0; c++) begin
      @(negedge clk);
      if (int'(big_addr) > maxa) maxa = int'(big_addr);
      if (big_valid) begin
        if (int'(big_pixel) != idx % 128 || int'(big_hcount) != idx % BW ||
            int'(big_vcount) != idx / BW) bad++;
        last_h = big_hcount;
        last_v = big_vcount;
        idx++;
        if (big_done) begin
          dcnt++;
          last_cyc = c;
        end
      end
    end
    check_output("big_beats", idx, BN);
    check_output("big_bad_beats", bad, 0);
    check_output("big_last_h", last_h, BW - 1);
    check_output("big_last_v", last_v, BH - 1);
    check_output("big_max_addr", maxa, BN - 1);
    check_output("big_done_pulses", dcnt, 1);
    check_output("big_final_cycle", last_cyc, BN + 3);
    tick();
    check_output("big_busy_after", big_busy, 0);
    big_finished = 1;
  end

  // Directed and random scenarios on the small instance
  initial begin
    int first_valid, d0;
    rst = 1'b1;
    start = 1'b0;
    ready = 1'b1;
    repeat (3) tick();
    check_output("rst_valid", valid, 0);
    check_output("rst_pixel", pixel, 0);
    check_output("rst_h", hcount, 0);
    check_output("rst_v", vcount, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_done", done, 0);
    check_output("rst_addr", addr, 0);
    rst = 1'b0;
    tick();

    // Scenario 1: latency and back-to-back beats
    first_valid = -1;
    d0 = done_cnt;
    for (int c = 0; c < 8; c++) begin
      start = (c == 0);
      if (c == 0) push_frame();
      @(negedge clk);
      if (c == 0) check_output("t1_busy_c0", busy, 0);
      if (c == 1) check_output("t1_busy_c1", busy, 1);
      if (valid && first_valid < 0) first_valid = c;
      tick();
    end
    start = 1'b0;
    check_output("t1_first_valid_cycle", first_valid, 4);
    wait_drain("t1", 60);
    check_output("t1_done_pulses", done_cnt - d0, 1);

    // Scenario 2: long stall right as data arrives
    for (int c = 0; c <= 13; c++) begin
      start = (c == 0);
      if (c == 0) push_frame();
      if (c == 3) ready = 1'b0;
      if (c == 13) ready = 1'b1;
      @(negedge clk);
      if (c == 12) begin
        check_output("t2_reads_capped", addr, DEPTH - 1);
        check_output("t2_valid_stalled", valid, 1);
        check_output("t2_pix_stalled", pixel, 0);
      end
      tick();
    end
    start = 1'b0;
    wait_drain("t2", 60);

    // Scenario 3: random backpressure
    d0 = done_cnt;
    start = 1'b1;
    push_frame();
    ready = 1'($urandom_range(0, 1));
    tick();
    start = 1'b0;
    for (int k = 0; k < 400 && (exp_q.size() != 0 || busy); k++) begin
      ready = 1'($urandom_range(0, 1));
      tick();
    end
    ready = 1'b1;
    wait_drain("t3", 60);
    check_output("t3_done_pulses", done_cnt - d0, 1);

    // Scenario 4: start pulses while busy, including on the final transfer
    for (int c = 0; c <= 25; c++) begin
      start = (c == 0 || c == 8 || c == 15);
      if (c == 0) push_frame();
      @(negedge clk);
      if (c == 15) check_output("t4_done_at_c15", done, 1);
      tick();
    end
    start = 1'b0;
    check_output("t4_no_requeue_busy", busy, 0);
    check_output("t4_no_requeue_queue", exp_q.size(), 0);
    start = 1'b1;
    push_frame();
    tick();
    start = 1'b0;
    wait_drain("t4b", 60);

    // Scenario 5: asynchronous reset in the middle of beat 6
    for (int c = 0; c <= 9; c++) begin
      start = (c == 0);
      if (c == 0) push_frame();
      @(negedge clk);
      if (c != 9) tick();
    end
    start = 1'b0;
    #1 rst = 1'b1;
    #1;
    check_output("t5_rst_valid", valid, 0);
    check_output("t5_rst_pixel", pixel, 0);
    check_output("t5_rst_h", hcount, 0);
    check_output("t5_rst_v", vcount, 0);
    check_output("t5_rst_busy", busy, 0);
    check_output("t5_rst_addr", addr, 0);
    exp_q.delete();
    repeat (2) tick();
    rst = 1'b0;
    tick();
    start = 1'b1;
    push_frame();
    tick();
    start = 1'b0;
    wait_drain("t5", 60);

    wait (big_finished);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Watchdog so a hung design still terminates
  initial begin
    #1500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
